// File: rtl/muldiv_alu.sv
// muldiv_alu: registered ALU with iterative radix-2 signed/unsigned multiply and divide
module muldiv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

    state_t             state;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   mb;
    logic               sa, sb, is_div;

    logic               is_md, sgn_op;
    logic [WIDTH-1:0]   sum, diff, alu_res, a_abs, b_abs;
    logic               alu_ovf;
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_ge, dbz;
    logic [WIDTH-1:0]   div_rem, quot, rem, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] p_next, prod;

    // single-cycle ALU result and signed-overflow detection
    always_comb begin
        sum     = port_a + port_b;
        diff    = port_a - port_b;
        alu_res = '0;
        case (op)
            4'd0:    alu_res = port_b << port_a[SHW-1:0];
            4'd1:    alu_res = port_b >> port_a[SHW-1:0];
            4'd2:    alu_res = sum;
            4'd3:    alu_res = diff;
            4'd4:    alu_res = port_a & port_b;
            4'd5:    alu_res = port_a | port_b;
            4'd6:    alu_res = port_a ^ port_b;
            4'd7:    alu_res = ~(port_a | port_b);
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, $signed(port_a) < $signed(port_b)};
            4'd9:    alu_res = {{(WIDTH-1){1'b0}}, port_a < port_b};
            default: alu_res = '0;
        endcase
        alu_ovf = (op == 4'd2) ? (port_a[WIDTH-1] == port_b[WIDTH-1]) && (sum[WIDTH-1] != port_a[WIDTH-1]) :
                  (op == 4'd3) ? (port_a[WIDTH-1] != port_b[WIDTH-1]) && (diff[WIDTH-1] != port_a[WIDTH-1]) : 1'b0;
    end

    // operand conditioning, one mul/div iteration step and final sign correction
    always_comb begin
        is_md   = (op >= 4'd10) && (op <= 4'd13);
        sgn_op  = ~op[0];
        a_abs   = (sgn_op && port_a[WIDTH-1]) ? -port_a : port_a;
        b_abs   = (sgn_op && port_b[WIDTH-1]) ? -port_b : port_b;
        mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mb} : '0);
        div_sh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, mb};
        div_rem = div_ge ? div_sh[WIDTH-1:0] - mb : div_sh[WIDTH-1:0];
        p_next  = is_div ? {div_rem, p[WIDTH-2:0], div_ge} : {mul_sum, p[WIDTH-1:1]};
        prod    = (sa ^ sb) ? -p : p;
        quot    = (sa ^ sb) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem     = sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
        dbz     = is_div && (mb == '0);
        fix_hi  = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        fix_lo  = is_div ? (dbz ? '1 : quot) : prod[WIDTH-1:0];
    end

    // control FSM with registered outputs; flush aborts an in-flight mul/div silently
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            cnt         <= '0;
            p           <= '0;
            mb          <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            is_div      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            hi          <= '0;
            lo          <= '0;
            negative    <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_md) begin
                        state  <= ITER;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[2];
                        sa     <= sgn_op & port_a[WIDTH-1];
                        sb     <= sgn_op & port_b[WIDTH-1];
                        p      <= {{WIDTH{1'b0}}, a_abs};
                        mb     <= b_abs;
                    end else if (start) begin
                        result   <= alu_res;
                        negative <= alu_res[WIDTH-1];
                        zero     <= alu_res == '0;
                        overflow <= alu_ovf;
                        done     <= 1'b1;
                    end
                end
                ITER: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        p   <= p_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == SHW'(WIDTH-1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi       <= fix_hi;
                        lo       <= fix_lo;
                        result   <= fix_lo;
                        negative <= fix_lo[WIDTH-1];
                        zero     <= fix_lo == '0;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        if (is_div) div_by_zero <= dbz;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_alu.sv
// tb_muldiv_alu: directed checks of muldiv_alu at WIDTH=32 and WIDTH=8
module tb_muldiv_alu;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0, flush = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, negative, zero, overflow, dbz;
    logic [31:0] result, hi, lo;

    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, negative8, zero8, overflow8, dbz8;
    logic [7:0]  result8, hi8, lo8;

    int n_checks = 0;
    int n_fail = 0;
    int lat, nb;

    muldiv_alu #(.WIDTH(32)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .flush(flush), .op(op),
        .port_a(a), .port_b(b), .busy(busy), .done(done), .result(result),
        .hi(hi), .lo(lo), .negative(negative), .zero(zero), .overflow(overflow),
        .div_by_zero(dbz)
    );

    muldiv_alu #(.WIDTH(8)) dut8 (
        .CLK(CLK), .nRST(nRST), .start(start8), .flush(flush8), .op(op8),
        .port_a(a8), .port_b(b8), .busy(busy8), .done(done8), .result(result8),
        .hi(hi8), .lo(lo8), .negative(negative8), .zero(zero8), .overflow(overflow8),
        .div_by_zero(dbz8)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int bc);
        l = 1; bc = 0;
        while (!done && l < 200) begin
            if (busy) bc++;
            @(posedge CLK); #1;
            l++;
        end
    endtask

    task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge CLK); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int l);
        l = 1;
        while (!done8 && l < 200) begin
            @(posedge CLK); #1;
            l++;
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", result, 0);
        check("rst_hi_lo", {hi, lo}, 0);
        check("rst_flags", {busy, done, negative, zero, overflow, dbz}, 0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        issue(4'd2, 32'h7FFF_FFFF, 32'h1);
        check("add_ovf_res", result, 32'h8000_0000);
        check("add_ovf_flags", {done, busy, overflow, negative, zero}, 5'b10110);
        @(posedge CLK); #1;
        check("add_done_pulse", done, 0);

        issue(4'd3, 32'h8000_0000, 32'h1);
        check("sub_ovf", {result, overflow}, {32'h7FFF_FFFF, 1'b1});
        issue(4'd0, 32'd4, 32'h1);
        check("sll", result, 32'h10);
        issue(4'd1, 32'd31, 32'h8000_0000);
        check("srl", result, 32'h1);
        issue(4'd4, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        check("and", result, 32'h00F0_F000);
        issue(4'd5, 32'hF000_0000, 32'h0000_000F);
        check("or", result, 32'hF000_000F);
        issue(4'd6, 32'hFFFF_0000, 32'hFF00_FF00);
        check("xor", result, 32'h00FF_FF00);
        issue(4'd7, 32'h0, 32'h0);
        check("nor", {result, negative}, {32'hFFFF_FFFF, 1'b1});
        issue(4'd8, 32'hFFFF_FFFF, 32'h1);
        check("slt", result, 32'h1);
        issue(4'd9, 32'hFFFF_FFFF, 32'h1);
        check("sltu", {result, zero}, {32'h0, 1'b1});
        issue(4'd14, 32'h5, 32'h6);
        check("reserved", {result, zero, done, hi, lo}, {32'h0, 1'b1, 1'b1, 64'h0});

        issue(4'd10, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, nb);
        check("mult_lat", lat, 34);
        check("mult_busy_cycles", nb, 33);
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mult_res_flags", {result, negative, busy}, {32'hFFFF_FFEB, 1'b1, 1'b0});

        issue(4'd12, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, nb);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'd13, 32'd7, 32'd0);
        wait_done(lat, nb);
        check("divu_by0", {hi, lo, dbz}, {64'h0000_0007_FFFF_FFFF, 1'b1});

        issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nb);
        check("div_ovf", {hi, lo, overflow, dbz}, {64'h0000_0000_8000_0000, 2'b00});

        issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, nb);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(4'd11, 32'd3, 32'd5);
        repeat (4) @(posedge CLK);
        #1;
        start = 1'b1; op = 4'd3; a = 32'd9; b = 32'd1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("busy_start_ignored", {done, busy, result}, {1'b0, 1'b1, 32'h1});
        repeat (4) @(posedge CLK);
        #1;
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check("flush_state", {busy, done}, 2'b00);
        check("flush_hold", {hi, lo, result}, {64'hFFFF_FFFE_0000_0001, 32'h1});
        issue(4'd3, 32'd5, 32'd3);
        check("sub_after_flush", {result, done}, {32'd2, 1'b1});
        lat = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) lat++;
        end
        check("no_late_done", {lat[7:0], hi, lo}, {8'd0, 64'hFFFF_FFFE_0000_0001});

        issue(4'd13, 32'd9, 32'd0);
        wait_done(lat, nb);
        check("divu_by0_b", dbz, 1);
        issue(4'd12, 32'd100, 32'd7);
        repeat (3) @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        check("async_rst_state", {busy, done, dbz, negative, zero, overflow}, 0);
        check("async_rst_data", {result, hi, lo}, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        check("rst_release_idle", {busy, done}, 0);

        issue8(4'd2, 8'h7F, 8'h01);
        check("w8_add_ovf", {result8, overflow8, negative8, done8}, {8'h80, 3'b111});
        issue8(4'd10, 8'h80, 8'h80);
        wait_done8(lat);
        check("w8_mult_lat", lat, 10);
        check("w8_mult_hilo", {hi8, lo8, zero8}, {16'h4000, 1'b1});
        issue8(4'd12, 8'h80, 8'hFF);
        wait_done8(lat);
        check("w8_div_ovf", {hi8, lo8, overflow8}, {16'h0080, 1'b0});
        issue8(4'd12, 8'hF9, 8'h02);
        wait_done8(lat);
        check("w8_div_neg", {hi8, lo8}, 16'hFFFD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_alu.md
Name: muldiv_alu

Overview:
- Parametrised, registered successor to the datapath ALU.
- Executes the ten single-cycle ALU operations with one cycle of latency.
- Adds iterative radix-2 multiply and divide, signed and unsigned, producing a double-width hi/lo result.
- Sits in the execute stage. The stall logic watches busy/done; hi/lo feed the MFHI/MFLO path.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, >= 8
SHW, $clog2(WIDTH), shift-amount width (derived; not to be overridden)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous reset, active low
start  in  1  request; sampled only while busy=0
flush  in  1  synchronous abort of an in-flight mul/div
op  in  4  operation select: 0 SLL, 1 SRL, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14-15 reserved
port_a  in  WIDTH  operand A; for shifts, port_a[SHW-1:0] is the shift amount
port_b  in  WIDTH  operand B; for shifts, the value shifted
busy  out  1  mul/div in progress
done  out  1  one-cycle pulse: result/flags (and hi/lo for mul/div) updated
result  out  WIDTH  registered result; equals lo for mul/div
hi  out  WIDTH  mul: upper product; div: remainder
lo  out  WIDTH  mul: lower product; div: quotient
negative  out  1  result[WIDTH-1]
zero  out  1  result == 0
overflow  out  1  signed overflow, ADD/SUB only
div_by_zero  out  1  last DIV/DIVU had port_b == 0

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE; iteration counter 0.
  - Reset is async assert, synchronous release to the clock edge.
- FSM states: IDLE, ITER, FIXUP.
- IDLE, start=1, op 0-9 or 14-15:
  - Compute at that edge; result and flags valid the next cycle.
  - done=1 for exactly one cycle; remain in IDLE.
  - hi/lo unchanged.
- IDLE, start=1, op 10-13:
  - Latch the absolute values of the operands (raw values for the unsigned ops) and the sign bits; go to ITER.
  - busy=1 starting the next cycle; counter=0.
- ITER:
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle.
  - After WIDTH steps (counter == WIDTH-1), go to FIXUP.
- FIXUP:
  - Apply sign correction; write hi/lo/result/flags.
  - busy=0, done=1 the next cycle; return to IDLE.
- Latency: single-cycle ops 1 cycle; mul/div WIDTH+2 cycles from the start edge to the done cycle.
- Back-to-back starts:
  - A new start is accepted in the same cycle done is high, provided busy=0.
  - start while busy=1 is ignored, with no side effect.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow=1 when the operands have the same sign (ADD) or opposite signs (SUB, a-b) and the result sign differs from A.
  - overflow=0 for all other ops.
  - SLL/SRL are logical, shift amount 0..WIDTH-1.
  - SLT is signed, SLTU unsigned; result is 1 or 0.
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - DIV overflow, most-negative / -1: lo = most-negative, hi = 0, overflow stays 0.
- Divide by zero, both signednesses: lo = all ones, hi = port_a, div_by_zero=1.
- div_by_zero is cleared by the next completed DIV/DIVU with a nonzero divisor.
- Reserved ops: result=0, zero=1, done pulses.
- Flags for mul/div: negative/zero derived from lo.
- flush:
  - In ITER or FIXUP: return to IDLE next cycle, busy=0, no done.
  - hi/lo/result/flags hold their prior values.
  - flush in IDLE has no effect.
  - flush and start in the same IDLE cycle: start is taken.
- Reset mid-operation: immediate return to the reset state; partial results are discarded.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 -> next cycle result=0x80000000, overflow=1, negative=1, done=1 for one cycle, busy stays 0.
- MULT a=-3 (0xFFFFFFFD), b=7 -> busy high for 33 cycles, done at cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, overflow=0. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.
- Start MULTU, pulse start with SUB at iteration 5 (ignored), flush at iteration 10 -> no done, hi/lo unchanged. Then SUB 5-3 issued the next cycle -> result=2.
- nRST dropped mid-DIV (async, between edges) -> all outputs 0 immediately. Also repeat the scenarios at WIDTH=8: MULT 0x80*0x80 -> hi=0x40, lo=0x00, latency 10 cycles.
